// File: rtl/systolic_operand_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: FSM encoding,
// flush-length expression and a clog2 helper for counter widths.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

   localparam int DEFAULT_ROWS      = 32;
   localparam int DEFAULT_COLS      = 32;
   localparam int DEFAULT_FLUSH_LEN = DEFAULT_ROWS + DEFAULT_COLS - 2;

   // Cycles from the last beat until its operands reach the far corner PE.
   function automatic int flush_len(input int rows, input int cols);
      return rows + cols - 2;
   endfunction

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Operand-side and array-side signal bundle of the systolic operand feeder.
// With FEEDER_PERF_CNT_EN defined it also carries beat_cnt and bubble_cnt.
interface systolic_operand_feeder_if #(
   parameter int ROWS      = 32,
   parameter int COLS      = 32,
   parameter int WORD_SIZE = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_last;
   logic [ROWS*WORD_SIZE-1:0] a_vec;
   logic [COLS*WORD_SIZE-1:0] b_vec;
   logic [ROWS*WORD_SIZE-1:0] left_in_bus;
   logic [COLS*WORD_SIZE-1:0] top_in_bus;
   logic                      ctl_stat_bit_in;
   logic                      busy;
   logic                      done;
`ifdef FEEDER_PERF_CNT_EN
   logic [31:0]               beat_cnt;
   logic [31:0]               bubble_cnt;
`endif

   modport master (
      output in_valid, in_last, a_vec, b_vec,
      input  in_ready, left_in_bus, top_in_bus, ctl_stat_bit_in, busy, done
`ifdef FEEDER_PERF_CNT_EN
      , input beat_cnt, bubble_cnt
`endif
   );

   modport slave (
      input  in_valid, in_last, a_vec, b_vec,
      output in_ready, left_in_bus, top_in_bus, ctl_stat_bit_in, busy, done
`ifdef FEEDER_PERF_CNT_EN
      , output beat_cnt, bubble_cnt
`endif
   );

endinterface

// File: rtl/systolic_operand_feeder_skew_delay_line.sv
// Fixed-depth register chain that delays one operand lane by DEPTH cycles.
module skew_delay_line #(
   parameter int DEPTH     = 1,
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] d,
   output logic [WORD_SIZE-1:0] q
);

   logic [WORD_SIZE-1:0] r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Skews A/B operand lanes into the output-stationary systolic array and flushes
// after the last beat. Define FEEDER_PERF_CNT_EN to add beat/bubble counters.
module systolic_operand_feeder
   import systolic_pkg::*;
#(
   parameter int ROWS      = 32,
   parameter int COLS      = 32,
   parameter int WORD_SIZE = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   systolic_operand_feeder_if.slave feed
);

   localparam int FLUSH_LEN = flush_len(ROWS, COLS);
   localparam int CNT_W     = (clog2(FLUSH_LEN + 1) > 0) ? clog2(FLUSH_LEN + 1) : 1;

   feeder_state_t             r_state;
   feeder_state_t             w_nextState;
   logic [CNT_W-1:0]          r_flushCnt;
   logic [CNT_W-1:0]          w_nextFlushCnt;
   logic                      r_ctlStat;
   logic                      w_inReady;
   logic                      w_accept;
   logic                      w_active;
   logic                      w_nextActive;
   logic [ROWS*WORD_SIZE-1:0] w_leftBus;
   logic [COLS*WORD_SIZE-1:0] w_topBus;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_flushCnt <= '0;
         r_ctlStat  <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_flushCnt <= w_nextFlushCnt;
         r_ctlStat  <= w_nextActive;
      end
   end

   // Accept-enable is derived from state only, so it is safe to use in the same block.
   always_comb begin
      w_nextState    = r_state;
      w_nextFlushCnt = r_flushCnt;
      w_inReady      = (r_state == IDLE) || (r_state == STREAM);
      w_accept       = feed.in_valid && w_inReady;
      w_active       = (r_state == STREAM) || (r_state == FLUSH);
      case (r_state)
         IDLE, STREAM: begin
            if (w_accept) begin
               if (feed.in_last) begin
                  w_nextState    = FLUSH;
                  w_nextFlushCnt = CNT_W'(FLUSH_LEN);
               end else begin
                  w_nextState = STREAM;
               end
            end
         end
         FLUSH: begin
            if (r_flushCnt == '0) begin
               w_nextState = DONE;
            end else begin
               w_nextFlushCnt = r_flushCnt - CNT_W'(1);
            end
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
      w_nextActive = (w_nextState == STREAM) || (w_nextState == FLUSH);
   end

   assign feed.in_ready        = w_inReady;
   assign feed.busy            = w_active;
   assign feed.done            = (r_state == DONE);
   assign feed.ctl_stat_bit_in = r_ctlStat;

   // Unaccepted cycles push zeros so bubbles stay diagonally aligned.
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      logic [WORD_SIZE-1:0] w_d;
      assign w_d = w_accept ? feed.a_vec[(gr+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
      skew_delay_line #(.DEPTH(gr + 1), .WORD_SIZE(WORD_SIZE)) u_delay (
         .clk (clk),
         .rst (rst),
         .d   (w_d),
         .q   (w_leftBus[(gr+1)*WORD_SIZE-1 -: WORD_SIZE])
      );
   end

   for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic [WORD_SIZE-1:0] w_d;
      assign w_d = w_accept ? feed.b_vec[(gc+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
      skew_delay_line #(.DEPTH(gc + 1), .WORD_SIZE(WORD_SIZE)) u_delay (
         .clk (clk),
         .rst (rst),
         .d   (w_d),
         .q   (w_topBus[(gc+1)*WORD_SIZE-1 -: WORD_SIZE])
      );
   end

   assign feed.left_in_bus = w_leftBus;
   assign feed.top_in_bus  = w_topBus;

`ifdef FEEDER_PERF_CNT_EN
   logic [31:0] r_beatCnt;
   logic [31:0] r_bubbleCnt;

   // A new stream starts from an accept in IDLE, which restarts both counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beatCnt   <= '0;
         r_bubbleCnt <= '0;
      end else if (w_accept && (r_state == IDLE)) begin
         r_beatCnt   <= 32'd1;
         r_bubbleCnt <= '0;
      end else begin
         if (w_accept && (r_beatCnt != '1)) r_beatCnt <= r_beatCnt + 32'd1;
         if ((r_state == STREAM) && !w_accept && (r_bubbleCnt != '1)) begin
            r_bubbleCnt <= r_bubbleCnt + 32'd1;
         end
      end
   end

   assign feed.beat_cnt   = r_beatCnt;
   assign feed.bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder (ROWS=COLS=4, WORD_SIZE=16),
// covering FEEDER_PERF_CNT_EN counters when that macro is defined.
module tb_systolic_operand_feeder;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int W     = 16;
   localparam int AW    = ROWS * W;
   localparam int BW    = COLS * W;
   localparam int FL    = ROWS + COLS - 2;
   localparam int HIST  = 64;
   localparam int P_IDLE   = 0;
   localparam int P_STREAM = 1;
   localparam int P_FLUSH  = 2;
   localparam int P_DONE   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_operand_feeder_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) feed ();

   systolic_operand_feeder #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .feed (feed.slave)
   );

   typedef struct {
      logic          valid;
      logic          last;
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic          expReady;
      logic          expBusy;
      logic          expDone;
      logic [AW-1:0] expLeft;
      logic [BW-1:0] expTop;
   } vec_t;

   vec_t vecs [10];

   int nChecks = 0;
   int nFails  = 0;
   int doneSeen = 0;

   // Reference model: phase from timing rules, lane data from accepted-beat history.
   int            edgeNo   = -1;
   int            lastEdge = -1;
   int            lastRst  = -1;
   int            curPhase = P_IDLE;
   bit            inStream = 1'b0;
   logic [AW-1:0] aHist [HIST];
   logic [BW-1:0] bHist [HIST];
   logic [31:0]   mBeats   = '0;
   logic [31:0]   mBubbles = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeNo, act, exp);
      end
   endtask

   task automatic modelEdge(input bit rstIn, input bit valid, input bit last,
                            input logic [AW-1:0] a, input logic [BW-1:0] b,
                            output bit accepted);
      int phBefore;
      int d;
      phBefore = curPhase;
      edgeNo++;
      accepted = !rstIn && valid && (phBefore == P_IDLE || phBefore == P_STREAM);
      aHist[edgeNo % HIST] = accepted ? a : '0;
      bHist[edgeNo % HIST] = accepted ? b : '0;
      if (rstIn) begin
         lastEdge = -1;
         inStream = 1'b0;
         lastRst  = edgeNo;
         mBeats   = '0;
         mBubbles = '0;
      end else begin
         if (accepted && phBefore == P_IDLE) begin
            mBeats   = 32'd1;
            mBubbles = '0;
         end else begin
            if (accepted && mBeats != '1) mBeats++;
            if (phBefore == P_STREAM && !accepted && mBubbles != '1) mBubbles++;
         end
         if (accepted && last) begin
            lastEdge = edgeNo;
            inStream = 1'b0;
         end else if (accepted) begin
            inStream = 1'b1;
         end
      end
      if (lastEdge >= 0) begin
         d = edgeNo - lastEdge;
         if (d <= FL)          curPhase = P_FLUSH;
         else if (d == FL + 1) curPhase = P_DONE;
         else begin
            curPhase = P_IDLE;
            lastEdge = -1;
         end
      end else begin
         curPhase = inStream ? P_STREAM : P_IDLE;
      end
   endtask

   function automatic logic [AW-1:0] expLeft();
      logic [AW-1:0] v;
      int k;
      v = '0;
      for (int r = 0; r < ROWS; r++) begin
         k = edgeNo - r;
         if (k > lastRst) v[r*W +: W] = aHist[k % HIST][r*W +: W];
      end
      return v;
   endfunction

   function automatic logic [BW-1:0] expTop();
      logic [BW-1:0] v;
      int k;
      v = '0;
      for (int c = 0; c < COLS; c++) begin
         k = edgeNo - c;
         if (k > lastRst) v[c*W +: W] = bHist[k % HIST][c*W +: W];
      end
      return v;
   endfunction

   task automatic checkOutput();
      bit expBusy;
      expBusy = (curPhase == P_STREAM) || (curPhase == P_FLUSH);
      check("in_ready", 64'(feed.in_ready), 64'(curPhase == P_IDLE || curPhase == P_STREAM));
      check("busy", 64'(feed.busy), 64'(expBusy));
      check("ctl_stat_bit_in", 64'(feed.ctl_stat_bit_in), 64'(expBusy));
      check("done", 64'(feed.done), 64'(curPhase == P_DONE));
      check("left_in_bus", 64'(feed.left_in_bus), 64'(expLeft()));
      check("top_in_bus", 64'(feed.top_in_bus), 64'(expTop()));
`ifdef FEEDER_PERF_CNT_EN
      check("beat_cnt", 64'(feed.beat_cnt), 64'(mBeats));
      check("bubble_cnt", 64'(feed.bubble_cnt), 64'(mBubbles));
`endif
      if (feed.done === 1'b1) doneSeen++;
   endtask

   task automatic applyStimulus(input bit rstIn, input bit valid, input bit last,
                                input logic [AW-1:0] a, input logic [BW-1:0] b,
                                output bit accepted);
      rst           = rstIn;
      feed.in_valid = valid;
      feed.in_last  = last;
      feed.a_vec    = a;
      feed.b_vec    = b;
      @(posedge clk);
      modelEdge(rstIn, valid, last, a, b, accepted);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idleStep();
      bit acc;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, acc);
   endtask

   task automatic drainToIdle();
      for (int i = 0; i < 3 * (ROWS + COLS) && curPhase != P_IDLE; i++) idleStep();
      check("idle_after_drain", 64'(feed.in_ready), 64'(1));
   endtask

   initial begin
      bit acc;
      int hold;
      bit pendValid;
      bit pendLast;
      logic [AW-1:0] pa;
      logic [BW-1:0] pb;

      for (int i = 0; i < 10; i++) begin
         vecs[i].valid    = (i == 0);
         vecs[i].last     = (i == 0);
         vecs[i].a        = (i == 0) ? 64'h0004_0003_0002_0001 : 64'h0;
         vecs[i].b        = (i == 0) ? 64'h0008_0007_0006_0005 : 64'h0;
         vecs[i].expReady = (i >= 8);
         vecs[i].expBusy  = (i <= 6);
         vecs[i].expDone  = (i == 7);
         vecs[i].expLeft  = 64'h0;
         vecs[i].expTop   = 64'h0;
      end
      vecs[0].expLeft = 64'h0000_0000_0000_0001;  vecs[0].expTop = 64'h0000_0000_0000_0005;
      vecs[1].expLeft = 64'h0000_0000_0002_0000;  vecs[1].expTop = 64'h0000_0000_0006_0000;
      vecs[2].expLeft = 64'h0000_0003_0000_0000;  vecs[2].expTop = 64'h0000_0007_0000_0000;
      vecs[3].expLeft = 64'h0004_0000_0000_0000;  vecs[3].expTop = 64'h0008_0000_0000_0000;

      feed.in_valid = 1'b0;
      feed.in_last  = 1'b0;
      feed.a_vec    = '0;
      feed.b_vec    = '0;

      $display("[TB] reset and idle");
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, acc);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, acc);
      for (int i = 0; i < 5; i++) idleStep();
      check("reset_no_done", 64'(doneSeen), 64'(0));

      $display("[TB] single beat table");
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, vecs[i].valid, vecs[i].last, vecs[i].a, vecs[i].b, acc);
         check($sformatf("tbl_ready[%0d]", i), 64'(feed.in_ready), 64'(vecs[i].expReady));
         check($sformatf("tbl_busy[%0d]", i), 64'(feed.busy), 64'(vecs[i].expBusy));
         check($sformatf("tbl_done[%0d]", i), 64'(feed.done), 64'(vecs[i].expDone));
         check($sformatf("tbl_left[%0d]", i), 64'(feed.left_in_bus), 64'(vecs[i].expLeft));
         check($sformatf("tbl_top[%0d]", i), 64'(feed.top_in_bus), 64'(vecs[i].expTop));
      end
      check("tbl_done_once", 64'(doneSeen), 64'(1));

      $display("[TB] four back-to-back beats");
      doneSeen = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, (i == 3),
                       {16'(i*16+3), 16'(i*16+2), 16'(i*16+1), 16'(i*16+0)},
                       {16'(i*16+11), 16'(i*16+10), 16'(i*16+9), 16'(i*16+8)}, acc);
      end
      drainToIdle();
      check("b2b_done_once", 64'(doneSeen), 64'(1));

      $display("[TB] two-cycle bubble mid-stream");
      for (int i = 0; i < 6; i++) begin
         if (i == 2 || i == 3) idleStep();
         else applyStimulus(1'b0, 1'b1, (i == 5), {4{16'(16'h100 + i)}}, {4{16'(16'h200 + i)}}, acc);
      end
      drainToIdle();
`ifdef FEEDER_PERF_CNT_EN
      check("gap_bubble_cnt", 64'(feed.bubble_cnt), 64'(2));
      check("gap_beat_cnt", 64'(feed.beat_cnt), 64'(4));
`endif

      $display("[TB] reset during flush");
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, acc);
      for (int i = 0; i < 3; i++) idleStep();
      doneSeen = 0;
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, acc);
      check("rst_flush_ready", 64'(feed.in_ready), 64'(1));
      check("rst_flush_left", 64'(feed.left_in_bus), 64'(0));
      check("rst_flush_top", 64'(feed.top_in_bus), 64'(0));
      check("rst_flush_busy", 64'(feed.busy), 64'(0));
      for (int i = 0; i < FL + 4; i++) idleStep();
      check("rst_flush_no_done", 64'(doneSeen), 64'(0));

      $display("[TB] valid held through flush");
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h0A0A_0B0B_0C0C_0D0D, 64'h0E0E_0F0F_1010_1111, acc);
      hold = 0;
      acc  = 1'b0;
      while (!acc && hold < 3 * (ROWS + COLS)) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 64'hBEEF_CAFE_F00D_D00D, 64'h1234_5678_9ABC_DEF0, acc);
         hold++;
      end
      check("held_beat_ready_seen", 64'(acc), 64'(1));
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h0101_0202_0303_0404, 64'h0505_0606_0707_0808, acc);
      drainToIdle();

      $display("[TB] randomized traffic");
      pendValid = 1'b0;
      pendLast  = 1'b0;
      pa = '0;
      pb = '0;
      for (int i = 0; i < 400; i++) begin
         bit doRst;
         doRst = ($urandom_range(0, 99) == 0);
         if (!pendValid) begin
            pendValid = ($urandom_range(0, 9) < 7);
            pendLast  = ($urandom_range(0, 7) == 0);
            pa = {$urandom, $urandom};
            pb = {$urandom, $urandom};
         end
         applyStimulus(doRst, pendValid, pendLast, pa, pb, acc);
         if (acc || doRst) pendValid = 1'b0;
      end
      drainToIdle();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/systolic_operand_feeder.md
# systolic_operand_feeder

Drives the operand edges of the output-stationary systolic MAC array. Accepts one A-column vector (ROWS words) and one B-row vector (COLS words) per handshake beat and applies the diagonal skew the array needs: row lane r is delayed r cycles and column lane c is delayed c cycles. After the last beat it flushes zeros until the final operands have reached PE (ROWS-1, COLS-1), then pulses done. It sits between the operand buffers and the array's left_in_bus/top_in_bus/ctl_stat_bit_in inputs.

## Interface
- ROWS, 32, array rows = number of left lanes
- COLS, 32, array columns = number of top lanes
- WORD_SIZE, 16, operand width in bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  feeder can accept a beat
- in_last  in  1  qualifies the final beat of the current K stream
- a_vec  in  ROWS*WORD_SIZE  lane r at [(r+1)*WORD_SIZE-1 -: WORD_SIZE]
- b_vec  in  COLS*WORD_SIZE  lane c at [(c+1)*WORD_SIZE-1 -: WORD_SIZE]
- left_in_bus  out  ROWS*WORD_SIZE  skewed A lanes to the array, same packing as a_vec
- top_in_bus  out  COLS*WORD_SIZE  skewed B lanes to the array, same packing as b_vec
- ctl_stat_bit_in  out  1  accumulate enable to every PE; high in STREAM and FLUSH
- busy  out  1  high in STREAM and FLUSH
- done  out  1  one-cycle pulse when the last product has been applied to the array

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE: in_ready=1. An accepted beat (in_valid&in_ready) moves the FSM to STREAM. If that beat also has in_last, the FSM goes directly to FLUSH.
- STREAM: in_ready=1. An accepted beat with in_last moves the FSM to FLUSH and loads flush_cnt = ROWS+COLS-2.
- FLUSH: in_ready=0. flush_cnt decrements each cycle. At 0 the FSM moves to DONE.
- DONE: done=1 and in_ready=0 for exactly one cycle, then IDLE.
- Delay lines:
  - Each lane has a register chain. Row lane r has depth r+1; column lane c has depth c+1.
  - Every cycle, the accepted beat's data is shifted in. If no beat is accepted, zero is shifted in (a bubble).
  - All lanes shift every cycle. There is no stall toward the array.
  - Bubbles stay diagonally aligned and contribute 0·x = 0 to the accumulators.
- ctl_stat_bit_in is registered from (state==STREAM || state==FLUSH). It is 0 in IDLE and DONE.
- No arithmetic on data; widths are passed through unchanged.
- Reset mid-operation: all delay registers are cleared, the FSM returns to IDLE, and flush_cnt=0. Partially fed data is discarded and done does not pulse.

## Timing
- Reset values: in_ready=1, left_in_bus=0, top_in_bus=0, ctl_stat_bit_in=0, busy=0, done=0.
- A beat accepted at edge t appears on row lane r at t+1+r and on column lane c at t+1+c.
- The last beat accepted at t: FLUSH spans t+1..t+ROWS+COLS-1, DONE is at t+ROWS+COLS, and the feeder is back in IDLE (in_ready=1) at t+ROWS+COLS+1.
- Back-to-back beats are accepted every cycle in IDLE and STREAM; throughput is 1 beat/cycle.
- in_last without in_valid is ignored.
- Beats are never accepted in FLUSH or DONE. The upstream must hold in_valid until in_ready=1.

## Configuration
- FEEDER_PERF_CNT_EN defined:
  - Adds output beat_cnt (32 bits) and output bubble_cnt (32 bits).
  - beat_cnt counts accepted beats.
  - bubble_cnt counts STREAM cycles with no accepted beat.
  - Both counters saturate at all-ones, reset on rst, and clear when IDLE is left for STREAM.
- FEEDER_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- The shared package systolic_pkg holds:
  - the FSM state encoding (2-bit IDLE=0, STREAM=1, FLUSH=2, DONE=3);
  - the FLUSH_LEN = ROWS+COLS-2 expression;
  - the clog2 helper for the flush_cnt width.
- Sub-module skew_delay_line: parameters DEPTH and WORD_SIZE, ports clk, rst, d, q. It is instantiated once per lane in generate loops.

## Test plan
All scenarios use ROWS=COLS=4 and WORD_SIZE=16.
- Reset then idle, no valid -> all buses 0, ctl_stat_bit_in=0, in_ready=1, done never asserts.
- One beat (a_vec lanes 1,2,3,4; b_vec lanes 5,6,7,8) with in_last at t -> left lane r shows r+1 at t+1+r; top lane c shows c+5 at t+1+c; all other cycles show 0; done at t+8.
- Four back-to-back beats, last with in_last -> each lane outputs its four values on consecutive cycles with the correct skew; busy is high from the first accept until done; done pulses once.
- Stream with in_valid low for 2 cycles mid-stream -> a 2-cycle zero bubble appears diagonally on all lanes; bubble_cnt=2 with FEEDER_PERF_CNT_EN.
- rst asserted in the middle of FLUSH -> next cycle all outputs are 0, state is IDLE, in_ready=1, and no done pulse.
- in_valid held during FLUSH/DONE -> not accepted until in_ready rises; that beat starts a new stream and its data is not lost.
